// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, one transaction at a time.
// Default build: data-over-fetch priority with a fetch starvation guard; define ARB_ROUND_ROBIN_EN for alternating priority.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    // load/store port
    input  logic            d_req,
    input  logic [DW/8-1:0] d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    // memory port
    output logic            m_req,
    output logic [DW/8-1:0] m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata
);

    localparam int BW = DW / 8;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            m_req_q, m_req_d;
    logic [BW-1:0]   m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic            i_rvalid_q, i_rvalid_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie the requester that was not served last wins.
    assign pick_d = d_req && (!i_req || (last_owner_q == OWN_I));

    always_comb begin
        last_owner_d = last_owner_q;
        if (d_gnt) begin
            last_owner_d = OWN_D;
        end else if (i_gnt) begin
            last_owner_d = OWN_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_I;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign pick_d = d_req && !(i_req && (starve_cnt_q == LIMIT));

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || i_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rvalid_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;

        if (state_q == IDLE) begin
            if (i_req || d_req) begin
                state_d = BUSY;
                m_req_d = 1'b1;
                if (pick_d) begin
                    d_gnt     = 1'b1;
                    owner_d   = OWN_D;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else begin
                    i_gnt     = 1'b1;
                    owner_d   = OWN_I;
                    m_we_d    = '0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                end
            end
        end else if (m_ack) begin
            state_d = IDLE;
            m_req_d = 1'b0;
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = (m_we_q == '0) ? m_rdata : '0;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = m_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            m_req_q    <= 1'b0;
            m_we_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a monitor pops them on each rvalid.
// Honours ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (i_rvalid || d_rvalid)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: i_rvalid=%0b d_rvalid=%0b, expected none at %0t",
                         i_rvalid, d_rvalid, $time);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_owner", {30'b0, i_rvalid, d_rvalid}, e.is_d ? 32'd1 : 32'd2);
                check("rdata", e.is_d ? d_rdata : i_rdata, e.data);
                $display("txn port=%s rdata=0x%08h expected=0x%08h", e.is_d ? "D" : "I",
                         e.is_d ? d_rdata : i_rdata, e.data);
            end
        end
    end

    // Zero-wait fetch with full latency checks.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        cyc();
        i_req  = 1'b1;
        i_addr = addr;
        mid();
        check("fetch_i_gnt", i_gnt, 1);
        check("fetch_d_gnt", d_gnt, 0);
        exp_q.push_back({1'b0, data});
        cyc();
        i_req   = 1'b0;
        m_ack   = 1'b1;
        m_rdata = data;
        mid();
        check("fetch_m_req", m_req, 1);
        check("fetch_m_addr", m_addr, addr);
        check("fetch_m_we", m_we, 0);
        check("busy_no_gnt", i_gnt, 0);
        cyc();
        m_ack = 1'b0;
        mid();
        check("fetch_rvalid_cycle2", i_rvalid, 1);
        check("fetch_m_req_cleared", m_req, 0);
        cyc();
        mid();
        check("fetch_rvalid_pulse", i_rvalid, 0);
    endtask

    initial begin
        logic [9:0] exp_seq;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = '0;
        d_addr  = '0;
        d_wdata = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        mid();
        check("rst_m_req", m_req, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_no_gnt", {31'b0, i_gnt | d_gnt}, 0);

        do_fetch(32'h0000_0100, 32'hDEAD_BEEF);

        // Store with ack delayed until the third busy cycle.
        cyc();
        d_req   = 1'b1;
        d_we    = 4'hF;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'h1234_5678;
        mid();
        check("store_d_gnt", d_gnt, 1);
        check("store_i_gnt", i_gnt, 0);
        exp_q.push_back({1'b1, 32'h0});
        cyc();
        d_req   = 1'b0;
        d_we    = '0;
        d_addr  = '0;
        d_wdata = '0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                m_ack   = 1'b1;
                m_rdata = 32'hFFFF_FFFF;
            end
            mid();
            check("store_m_req", m_req, 1);
            check("store_m_we", m_we, 4'hF);
            check("store_m_addr", m_addr, 32'h0000_2000);
            check("store_m_wdata", m_wdata, 32'h1234_5678);
            cyc();
        end
        m_ack = 1'b0;
        mid();
        check("store_d_rvalid", d_rvalid, 1);
        check("store_m_req_cleared", m_req, 0);

        // Load; fetch data must be untouched.
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h0000_0044;
        mid();
        check("load_d_gnt", d_gnt, 1);
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        cyc();
        d_req   = 1'b0;
        m_ack   = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        cyc();
        m_ack = 1'b0;
        mid();
        check("load_d_rvalid", d_rvalid, 1);
        check("i_rdata_held", i_rdata, 32'hDEAD_BEEF);

        // Stray ack in IDLE must be ignored.
        cyc();
        m_ack   = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
        mid();
        check("stray_m_req", m_req, 0);
        cyc();
        m_ack = 1'b0;
        mid();
        check("stray_no_busy", m_req, 0);
        do_fetch(32'h0000_0104, 32'h0BAD_F00D);

        // Asynchronous reset while a read is outstanding.
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h0000_0300;
        mid();
        check("rstbusy_i_gnt", i_gnt, 1);
        cyc();
        i_req = 1'b0;
        mid();
        check("rstbusy_m_req", m_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstbusy_m_req0", m_req, 0);
        check("rstbusy_m_addr0", m_addr, 0);
        check("rstbusy_i_rdata0", i_rdata, 0);
        check("rstbusy_d_rdata0", d_rdata, 0);
        check("rstbusy_rvalid0", {30'b0, i_rvalid, d_rvalid}, 0);
        cyc();
        m_ack   = 1'b1;
        m_rdata = 32'h7777_7777;
        cyc();
        m_ack = 1'b0;
        rst_n = 1'b1;
        cyc();
        cyc();
        mid();
        check("post_rst_idle", m_req, 0);

        // Both requesters held, zero-wait memory.
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 10'b0101010101;
`else
        exp_seq = 10'b0111101111;
`endif
        cyc();
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h0000_0400;
        d_addr = 32'h0000_0500;
        d_we   = '0;
        for (int n = 0; n < 10; n++) begin
            mid();
            check("gnt_onehot", {31'b0, i_gnt} + {31'b0, d_gnt}, 1);
            check("gnt_seq", d_gnt, exp_seq[n]);
            exp_q.push_back({exp_seq[n], 32'h0000_1000 + n});
            cyc();
            if (n == 9) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            m_ack   = 1'b1;
            m_rdata = 32'h0000_1000 + n;
            cyc();
            m_ack = 1'b0;
        end
        mid();
        cyc();
        mid();
        check("final_no_gnt", {31'b0, i_gnt | d_gnt}, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port unified memory between the RV32I core's instruction-fetch path and its load/store path. It replaces the separate instruction and data memories when the core targets a single memory macro or external bus. It grants one transaction at a time, holds the downstream request until the memory acknowledges, and returns a registered response to the owning requester. Fixed data-over-fetch priority is used, with a starvation guard for fetch.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)

- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch grant pulse (combinational, IDLE only)
- i_rvalid  out  1  one-cycle fetch response pulse
- i_rdata  out  DW  fetch data, valid with i_rvalid
- d_req  in  1  data request; held with d_* payload until d_gnt
- d_we  in  DW/8  byte write enables; 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data grant pulse (combinational, IDLE only)
- d_rvalid  out  1  one-cycle completion pulse, for reads and writes
- d_rdata  out  DW  load data; 0 for write completions
- m_req  out  1  memory request, registered, held until m_ack
- m_we  out  DW/8  registered byte enables
- m_addr  out  AW  registered address, passed through unaligned
- m_wdata  out  DW  registered write data
- m_ack  in  1  memory acknowledge; m_rdata valid same cycle
- m_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, BUSY. An owner register records I or D.
- IDLE: if any request is present, select a winner and assert its gnt in the same cycle. On the edge, latch the winner's payload into m_*, set m_req=1 and owner, then go to BUSY. With no request, stay in IDLE with m_req=0.
- Selection (default build):
  - d_req wins unless starve_cnt == STARVE_LIMIT and i_req=1, in which case fetch wins.
  - starve_cnt increments on each data grant while i_req=1.
  - starve_cnt clears on a fetch grant or on any cycle with i_req=0.
  - starve_cnt saturates at STARVE_LIMIT.
- BUSY: m_req and m_* stay stable. No gnt is asserted. On m_ack, capture m_rdata (or zero for writes) into the owner's rdata register, pulse the owner's rvalid on the next cycle, clear m_req, and return to IDLE.
- m_ack seen in IDLE is ignored.
- The non-owner's rvalid stays 0, and its rdata holds its previous value.
- Reset (asynchronous, any state): go to IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, i/d_rvalid=0, i/d_rdata=0, starve_cnt=0, owner=I. An in-flight transaction is dropped and no rvalid is produced for it.

## Timing
- Request in IDLE at cycle 0: gnt at cycle 0, m_req from cycle 1.
- With m_ack in cycle k≥1, rvalid is in cycle k+1. The FSM is in IDLE at k+1, so a new gnt can coincide with rvalid.
- Zero-wait memory (ack in cycle 1) gives 2-cycle latency and one transaction per 2 cycles.
- Simultaneous i_req and d_req: exactly one gnt per IDLE cycle; never both.
- A requester that drops req before gnt is simply not served. Payload change before gnt is allowed; the value latched is the one present in the gnt cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: fixed priority and starve_cnt are not compiled. A last-owner bit alternates priority: on simultaneous requests the requester that was not the last owner wins. A single requester always wins. last-owner resets to I, so data wins the first tie.
- Undefined: fixed data priority with the STARVE_LIMIT guard as described in Operation.

## Test plan
- Reset, then i_req=1, i_addr=0x100, m_ack in cycle 1 with m_rdata=0xDEADBEEF -> i_gnt cycle 0, m_req cycles 1, i_rvalid cycle 2, i_rdata=0xDEADBEEF, d_rvalid=0 throughout.
- d_req store, d_we=0xF, d_addr=0x2000, d_wdata=0x12345678, m_ack delayed 3 cycles -> m_* stable and m_req held for 3 cycles, d_rvalid one pulse after ack, d_rdata=0.
- i_req and d_req held continuously, STARVE_LIMIT=4, zero-wait memory -> grant sequence D,D,D,D,I,D,D,D,D,I. With ARB_ROUND_ROBIN_EN the sequence is D,I,D,I.
- Assert Reset low while BUSY with an un-acked read -> all outputs 0 immediately. No rvalid after release; the next request is served normally.
- m_ack pulsed while IDLE, then a normal fetch -> stray ack ignored and fetch returns correct data at the specified latency.
